// File: rtl/display_scan_scheduler_if.sv
//------------------------------------------------------------------------------
// Module   : display_scan_scheduler_if
// Brief    : Requester/display bundle between the time logic and the scan
//            scheduler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface display_scan_scheduler_if;
  logic [15:0] bcd_a;
  logic [3:0]  dp_a;
  logic [15:0] bcd_b;
  logic [3:0]  dp_b;
  logic        req_b;
  logic        grant_b;
  logic [3:0]  blink_mask;
  logic        lz_en;
  logic [3:0]  digit_sel;
  logic [3:0]  digit_val;
  logic        DP;
  logic        frame_start;

  modport master (
    output bcd_a, dp_a, bcd_b, dp_b, req_b, blink_mask, lz_en,
    input  grant_b, digit_sel, digit_val, DP, frame_start
  );

  modport slave (
    input  bcd_a, dp_a, bcd_b, dp_b, req_b, blink_mask, lz_en,
    output grant_b, digit_sel, digit_val, DP, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/display_scan_scheduler.sv
//------------------------------------------------------------------------------
// Module   : display_scan_scheduler
// Brief    : 4-digit 7-segment scan controller with frame-coherent A/B
//            arbitration, blank interval, blinking and leading-zero blanking.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module display_scan_scheduler #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK        = 500,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                     clk,
  input  logic                     rst_n,
  display_scan_scheduler_if.slave  bus
);

  localparam int CW = $clog2(PRESCALE);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] C_CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] C_BLANK    = CW'(BLANK);
  localparam logic [FW-1:0] C_FRM_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_run;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]  r_slot;
  logic [1:0]  w_slot_nxt;
  logic        w_boundary;

  logic [15:0] r_snap_bcd;
  logic [3:0]  r_snap_dp;
  logic [3:0]  r_snap_blink;
  logic        r_snap_lz;
  logic [15:0] w_snap_bcd_nxt;
  logic [3:0]  w_snap_dp_nxt;
  logic [3:0]  w_snap_blink_nxt;
  logic        w_snap_lz_nxt;

  logic [FW-1:0] r_fcnt;
  logic [FW-1:0] w_fcnt_nxt;
  logic        r_blink_phase;
  logic        w_blink_phase_nxt;

  logic        r_grant_b;
  logic        w_grant_b_nxt;
  logic [3:0]  r_digit_sel;
  logic [3:0]  r_digit_val;
  logic        r_dp;
  logic        r_frame_start;

  logic [3:0]  w_lz_supp;
  logic [3:0]  w_supp;
  logic [3:0]  w_digit_val_nxt;
  logic [3:0]  w_digit_sel_nxt;
  logic        w_dp_nxt;
  logic        w_lit;

  // The first cycle after reset release is position 0 of frame 0.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_slot_nxt = r_slot;
    if (!r_run) begin
      w_cnt_nxt  = '0;
      w_slot_nxt = 2'd0;
    end else if (r_cnt == C_CNT_LAST) begin
      w_cnt_nxt  = '0;
      w_slot_nxt = r_slot + 2'd1;
    end else begin
      w_cnt_nxt  = r_cnt + CW'(1);
    end
  end

  assign w_boundary = (w_cnt_nxt == '0) && (w_slot_nxt == 2'd0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BLANK: if (w_cnt_nxt == C_BLANK) w_state_nxt = S_DRIVE;
      S_DRIVE: if (w_cnt_nxt == '0)      w_state_nxt = S_BLANK;
      default: w_state_nxt = S_BLANK;
    endcase
  end

  // Arbitration and snapshot share one enable so a frame never mixes sources.
  always_comb begin
    w_grant_b_nxt    = r_grant_b;
    w_snap_bcd_nxt   = r_snap_bcd;
    w_snap_dp_nxt    = r_snap_dp;
    w_snap_blink_nxt = r_snap_blink;
    w_snap_lz_nxt    = r_snap_lz;
    if (w_boundary) begin
      w_grant_b_nxt    = bus.req_b;
      w_snap_bcd_nxt   = bus.req_b ? bus.bcd_b : bus.bcd_a;
      w_snap_dp_nxt    = bus.req_b ? bus.dp_b  : bus.dp_a;
      w_snap_blink_nxt = bus.blink_mask;
      w_snap_lz_nxt    = bus.lz_en;
    end
  end

  always_comb begin
    w_fcnt_nxt        = r_fcnt;
    w_blink_phase_nxt = r_blink_phase;
    if (w_boundary && r_run) begin
      if (r_fcnt == C_FRM_LAST) begin
        w_fcnt_nxt        = '0;
        w_blink_phase_nxt = ~r_blink_phase;
      end else begin
        w_fcnt_nxt        = r_fcnt + FW'(1);
      end
    end
  end

  always_comb begin
    w_lz_supp    = 4'b0000;
    w_lz_supp[3] = w_snap_lz_nxt && (w_snap_bcd_nxt[15:12] == 4'd0);
    w_lz_supp[2] = w_lz_supp[3]  && (w_snap_bcd_nxt[11:8]  == 4'd0);
    w_lz_supp[1] = w_lz_supp[2]  && (w_snap_bcd_nxt[7:4]   == 4'd0);
    w_supp       = w_lz_supp | (w_snap_blink_nxt & {4{w_blink_phase_nxt}});
  end

  // Outputs are computed from next-state values so they register in step
  // with the counter, snapshot and phase they describe.
  always_comb begin
    w_digit_val_nxt = w_snap_bcd_nxt[{w_slot_nxt, 2'b00} +: 4];
    w_lit           = (w_state_nxt == S_DRIVE) && !w_supp[w_slot_nxt];
    w_digit_sel_nxt = 4'b0000;
    w_dp_nxt        = 1'b1;
    if (w_lit) begin
      w_digit_sel_nxt = 4'b0001 << w_slot_nxt;
      w_dp_nxt        = ~w_snap_dp_nxt[w_slot_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BLANK;
      r_run         <= 1'b0;
      r_cnt         <= '0;
      r_slot        <= 2'd0;
      r_snap_bcd    <= 16'h0000;
      r_snap_dp     <= 4'b0000;
      r_snap_blink  <= 4'b0000;
      r_snap_lz     <= 1'b0;
      r_fcnt        <= '0;
      r_blink_phase <= 1'b0;
      r_grant_b     <= 1'b0;
      r_digit_sel   <= 4'b0000;
      r_digit_val   <= 4'b0000;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_run         <= 1'b1;
      r_cnt         <= w_cnt_nxt;
      r_slot        <= w_slot_nxt;
      r_snap_bcd    <= w_snap_bcd_nxt;
      r_snap_dp     <= w_snap_dp_nxt;
      r_snap_blink  <= w_snap_blink_nxt;
      r_snap_lz     <= w_snap_lz_nxt;
      r_fcnt        <= w_fcnt_nxt;
      r_blink_phase <= w_blink_phase_nxt;
      r_grant_b     <= w_grant_b_nxt;
      r_digit_sel   <= w_digit_sel_nxt;
      r_digit_val   <= w_digit_val_nxt;
      r_dp          <= w_dp_nxt;
      r_frame_start <= w_boundary;
    end
  end

  assign bus.grant_b     = r_grant_b;
  assign bus.digit_sel   = r_digit_sel;
  assign bus.digit_val   = r_digit_val;
  assign bus.DP          = r_dp;
  assign bus.frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_scheduler.sv
//------------------------------------------------------------------------------
// Module   : tb_display_scan_scheduler
// Brief    : Directed bench for display_scan_scheduler with an expected-output
//            queue filled per frame and drained cycle by cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_display_scan_scheduler;

  localparam int PRESCALE     = 8;
  localparam int BLANK        = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 4 * PRESCALE;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] val;
    logic       dp;
    logic       grant;
    logic       fs;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   pass_cnt;
  int   total_cnt;
  int   frame_no;
  int   cyc;

  display_scan_scheduler_if bus ();

  display_scan_scheduler #(
    .PRESCALE    (PRESCALE),
    .BLANK       (BLANK),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Expected frame built from the scan rules: blank lead-in, strobe unless
  // suppressed by leading zeros or the blink half-period.
  task automatic push_frame(input logic [15:0] bcd, input logic [3:0] dp,
                            input logic grant, input logic [3:0] mask, input logic lz);
    logic       phase;
    logic [3:0] sup;
    logic [3:0] nib [4];
    exp_t       e;
    phase = (((frame_no / BLINK_FRAMES) % 2) == 1);
    for (int d = 0; d < 4; d++) nib[d] = bcd[4*d +: 4];
    sup[0] = 1'b0;
    sup[3] = lz && (nib[3] == 4'd0);
    sup[2] = sup[3] && (nib[2] == 4'd0);
    sup[1] = sup[2] && (nib[1] == 4'd0);
    if (phase) sup = sup | mask;
    for (int p = 0; p < FRAME; p++) begin
      int s;
      int c;
      s = p / PRESCALE;
      c = p % PRESCALE;
      e.val   = nib[s];
      e.grant = grant;
      e.fs    = (p == 0);
      if (c < BLANK || sup[s]) begin
        e.sel = 4'b0000;
        e.dp  = 1'b1;
      end else begin
        e.sel = 4'(1 << s);
        e.dp  = ~dp[s];
      end
      sb.push_back(e);
    end
    frame_no++;
  endtask

  task automatic run_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
        total_cnt++;
        $error("FAIL sb_empty@%0d observed=empty expected=entry", cyc);
      end else begin
        e = sb.pop_front();
        chk($sformatf("sel@%0d", cyc),   16'(bus.digit_sel),   16'(e.sel));
        chk($sformatf("val@%0d", cyc),   16'(bus.digit_val),   16'(e.val));
        chk($sformatf("dp@%0d", cyc),    16'(bus.DP),          16'(e.dp));
        chk($sformatf("grant@%0d", cyc), 16'(bus.grant_b),     16'(e.grant));
        chk($sformatf("fs@%0d", cyc),    16'(bus.frame_start), 16'(e.fs));
      end
      cyc++;
    end
  endtask

  initial begin
    pass_cnt       = 0;
    total_cnt      = 0;
    frame_no       = 0;
    cyc            = 0;
    rst_n          = 1'b0;
    bus.bcd_a      = 16'h1234;
    bus.dp_a       = 4'b0100;
    bus.bcd_b      = 16'h0959;
    bus.dp_b       = 4'b1000;
    bus.req_b      = 1'b0;
    bus.blink_mask = 4'b0011;
    bus.lz_en      = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_sel",   16'(bus.digit_sel),   16'h0);
    chk("rst_val",   16'(bus.digit_val),   16'h0);
    chk("rst_dp",    16'(bus.DP),          16'h1);
    chk("rst_grant", 16'(bus.grant_b),     16'h0);
    chk("rst_fs",    16'(bus.frame_start), 16'h0);
    rst_n = 1'b1;

    // Frame 0: source A; B requested mid-frame.
    push_frame(16'h1234, 4'b0100, 1'b0, 4'b0011, 1'b0);
    run_cycles(10);
    bus.req_b = 1'b1;
    run_cycles(FRAME - 10);

    // Frame 1: B granted; request drops mid-frame but B is held.
    push_frame(16'h0959, 4'b1000, 1'b1, 4'b0011, 1'b0);
    run_cycles(8);
    bus.req_b = 1'b0;
    run_cycles(FRAME - 8);

    // Frames 2-3: A returns, slots 0 and 1 blinked off.
    push_frame(16'h1234, 4'b0100, 1'b0, 4'b0011, 1'b0);
    run_cycles(FRAME);
    push_frame(16'h1234, 4'b0100, 1'b0, 4'b0011, 1'b0);
    run_cycles(FRAME);

    // Frames 4-5: leading-zero suppression.
    bus.blink_mask = 4'b0000;
    bus.lz_en      = 1'b1;
    bus.bcd_a      = 16'h0040;
    push_frame(16'h0040, 4'b0100, 1'b0, 4'b0000, 1'b1);
    run_cycles(FRAME);
    bus.bcd_a = 16'h0000;
    push_frame(16'h0000, 4'b0100, 1'b0, 4'b0000, 1'b1);
    run_cycles(FRAME);

    // Frames 6-7: mid-frame data change must wait for the next frame.
    bus.lz_en = 1'b0;
    bus.dp_a  = 4'b0000;
    bus.bcd_a = 16'h1111;
    push_frame(16'h1111, 4'b0000, 1'b0, 4'b0000, 1'b0);
    run_cycles(10);
    bus.bcd_a = 16'h2222;
    run_cycles(FRAME - 10);
    push_frame(16'h2222, 4'b0000, 1'b0, 4'b0000, 1'b0);
    run_cycles(FRAME);

    // Frame 8: B granted, then reset during slot 2 drive.
    bus.req_b = 1'b1;
    push_frame(16'h0959, 4'b1000, 1'b1, 4'b0000, 1'b0);
    run_cycles(2 * PRESCALE + BLANK + 1);
    chk("pre_rst_sel", 16'(bus.digit_sel), 16'h4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_sel",   16'(bus.digit_sel), 16'h0);
    chk("async_dp",    16'(bus.DP),        16'h1);
    chk("async_grant", 16'(bus.grant_b),   16'h0);
    chk("async_val",   16'(bus.digit_val), 16'h0);
    sb.delete();
    @(negedge clk);
    bus.req_b = 1'b0;
    bus.bcd_a = 16'h1234;
    bus.dp_a  = 4'b0100;
    frame_no  = 0;
    rst_n     = 1'b1;
    push_frame(16'h1234, 4'b0100, 1'b0, 4'b0000, 1'b0);
    run_cycles(FRAME);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
